// File: rtl/debounce_btn_multi.sv
// N-channel push-button debouncer: 2-flop synchroniser, stable-count filter,
// press/release pulses and an optional long-press / auto-repeat pulse per channel.
module debounce_btn_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int HOLD_CYCLES   = 0,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] hold_pulse
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic            INACTIVE = (ACTIVE_LOW != 0);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             s1_q, s1_d, s2_q, s2_d;
    logic             deb_q, deb_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             p;

    always_comb begin
      s1_d    = btn_state[i];
      s2_d    = s1_q;
      p       = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;
      deb_d   = deb_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      // Any sample agreeing with the current state restarts the run.
      if (p == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_d   = p;
        cnt_d   = '0;
        press_d = p;
        rel_d   = ~p;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q    <= INACTIVE;
        s2_q    <= INACTIVE;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        s1_q    <= s1_d;
        s2_q    <= s2_d;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign debounced[i]     = deb_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = rel_q;

    if (HOLD_CYCLES > 0) begin : g_hold
      // state     | meaning
      // IDLE      | not pressed, waiting for a debounced press
      // WAIT_HOLD | pressed, timing out to the first hold pulse
      // REPEAT    | held past first pulse, auto-repeating
      // DONE      | single hold pulse issued, waiting for release
      localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
      localparam int HC_W = $clog2(HMAX + 1);
      localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
      localparam logic [HC_W-1:0] REP_LAST  = HC_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

      typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT, DONE} hold_state_e;

      hold_state_e     state_q, state_d;
      logic [HC_W-1:0] hcnt_q, hcnt_d;
      logic            hold_q, hold_d;

      always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        hold_d  = 1'b0;
        // Release wins over a hold pulse falling on the same edge.
        if (rel_d) begin
          state_d = IDLE;
          hcnt_d  = '0;
        end else begin
          case (state_q)
            IDLE: begin
              if (press_d) begin
                state_d = WAIT_HOLD;
                hcnt_d  = '0;
              end
            end
            WAIT_HOLD: begin
              if (hcnt_q == HOLD_LAST) begin
                hold_d = 1'b1;
                hcnt_d = '0;
                if (REPEAT_CYCLES > 0) state_d = REPEAT;
                else                   state_d = DONE;
              end else begin
                hcnt_d = hcnt_q + HC_W'(1);
              end
            end
            REPEAT: begin
              if (hcnt_q == REP_LAST) begin
                hold_d = 1'b1;
                hcnt_d = '0;
              end else begin
                hcnt_d = hcnt_q + HC_W'(1);
              end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= IDLE;
          hcnt_q  <= '0;
          hold_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          hcnt_q  <= hcnt_d;
          hold_q  <= hold_d;
        end
      end

      assign hold_pulse[i] = hold_q;
    end else begin : g_no_hold
      assign hold_pulse[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_btn_multi.sv
// Bench for debounce_btn_multi: a hold-enabled (10/5) and a default instance share
// stimulus; a sample-window reference model checks every cycle.
module tb_debounce_btn_multi;
  localparam int N = 4;
  localparam int S = 4;
  localparam int H = 10;
  localparam int R = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] deb_h, prs_h, rel_h, hld_h;
  logic [3:0] deb_d, prs_d, rel_d, hld_d;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  debounce_btn_multi #(.N_CH(4), .STABLE_CYCLES(4), .ACTIVE_LOW(1),
                       .HOLD_CYCLES(10), .REPEAT_CYCLES(5)) u_hold (
    .clk(clk), .rst(rst), .btn_state(btn), .debounced(deb_h),
    .press_pulse(prs_h), .release_pulse(rel_h), .hold_pulse(hld_h));

  debounce_btn_multi u_plain (
    .clk(clk), .rst(rst), .btn_state(btn), .debounced(deb_d),
    .press_pulse(prs_d), .release_pulse(rel_d), .hold_pulse(hld_d));

  // Reference model: sync as a 2-deep delay line, debounce as "last S samples all
  // disagree with the current state", hold from elapsed edges since the press.
  logic [3:0] m_deb, m_prs, m_rel, m_hld;
  bit         sq0 [4];
  bit         sq1 [4];
  int         hist [4];
  int         nval [4];
  int         press_t [4];
  int         t;
  bit         mp;
  int         md;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        sq0[c] = 1'b1; sq1[c] = 1'b1; hist[c] = 0; nval[c] = 0; press_t[c] = -1000;
      end
      m_deb = '0; m_prs = '0; m_rel = '0; m_hld = '0; t = 0;
    end else begin
      for (int c = 0; c < N; c++) begin
        mp = ~sq0[c];
        sq0[c] = sq1[c];
        sq1[c] = btn[c];
        hist[c] = ((hist[c] << 1) | int'(mp)) & ((1 << S) - 1);
        if (nval[c] < S) nval[c]++;
        m_prs[c] = 1'b0;
        m_rel[c] = 1'b0;
        if (nval[c] == S && hist[c] == (m_deb[c] ? 0 : (1 << S) - 1)) begin
          m_deb[c] = ~m_deb[c];
          if (m_deb[c]) begin m_prs[c] = 1'b1; press_t[c] = t; end
          else m_rel[c] = 1'b1;
        end
        md = t - press_t[c];
        m_hld[c] = m_deb[c] && md > 0 && (md == H || (md > H && (md - H) % R == 0));
      end
      t++;
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("deb_h", deb_h, m_deb);
    chk("press_h", prs_h, m_prs);
    chk("release_h", rel_h, m_rel);
    chk("hold_h", hld_h, m_hld);
    chk("deb_d", deb_d, m_deb);
    chk("press_d", prs_d, m_prs);
    chk("release_d", rel_d, m_rel);
    chk("hold_d", hld_d, 4'b0000);
  endtask

  task automatic wait_press(input int c);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      if (prs_h[c]) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_press ch%0d: no press_pulse within 20 cycles", c);
    end
  endtask

  typedef struct {
    logic [3:0] btn;
    int         cycles;
    logic [3:0] exp_deb;
    int         exp_prs;
    int         exp_rel;
    int         exp_hld;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n_prs, n_rel, n_hld;
    // bounce on ch1 (3/1/3), then ch2 long press with hold pulses, then release
    vecs[0] = '{4'b1101, 3,  4'b0000, 0, 0, 0};
    vecs[1] = '{4'b1111, 1,  4'b0000, 0, 0, 0};
    vecs[2] = '{4'b1101, 3,  4'b0000, 0, 0, 0};
    vecs[3] = '{4'b1111, 8,  4'b0000, 0, 0, 0};
    vecs[4] = '{4'b1011, 8,  4'b0100, 1, 0, 0};
    vecs[5] = '{4'b1011, 10, 4'b0100, 0, 0, 1};
    vecs[6] = '{4'b1011, 10, 4'b0100, 0, 0, 2};
    vecs[7] = '{4'b1111, 10, 4'b0000, 0, 1, 1};

    rst = 1'b1;
    btn = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_deb", deb_h, 4'b0000);
    chk("rst_pulses", prs_h | rel_h | hld_h, 4'b0000);
    rst = 1'b0;
    btn = 4'b1110;

    // press ch0: visible after edge 5 (step 6)
    for (int k = 1; k <= 7; k++) begin
      step();
      chk_i("t1_deb0", int'(deb_h[0]), int'(k >= 6));
      chk_i("t1_press0", int'(prs_h[0]), int'(k == 6));
      chk_i("t1_other", int'(deb_h[3:1]), 0);
    end

    // release ch0, 5 edges after capture
    btn = 4'b1111;
    for (int j = 0; j <= 5; j++) begin
      step();
      chk_i("t2_rel0", int'(rel_h[0]), int'(j == 5));
      chk_i("t2_deb0", int'(deb_h[0]), int'(j < 5));
      chk_i("t2_hold", int'(hld_h), 0);
    end

    for (int v = 0; v < 8; v++) begin
      btn = vecs[v].btn;
      n_prs = 0; n_rel = 0; n_hld = 0;
      for (int k = 0; k < vecs[v].cycles; k++) begin
        step();
        n_prs += $countones(prs_h);
        n_rel += $countones(rel_h);
        n_hld += $countones(hld_h);
      end
      chk("vec_deb", deb_h, vecs[v].exp_deb);
      chk_i("vec_press", n_prs, vecs[v].exp_prs);
      chk_i("vec_release", n_rel, vecs[v].exp_rel);
      chk_i("vec_hold", n_hld, vecs[v].exp_hld);
    end

    // 40-cycle hold on ch2: pulses at +10..+40 step 5, release lands at +43
    btn = 4'b1011;
    wait_press(2);
    for (int k = 1; k <= 50; k++) begin
      step();
      chk_i("hold40_hold2", int'(hld_h[2]), int'(k >= 10 && k <= 40 && k % 5 == 0));
      chk_i("hold40_rel2", int'(rel_h[2]), int'(k == 43));
      if (k == 37) btn = 4'b1111;
    end

    // ch0+ch3 together; ch3 releases early, ch0 release coincides with hold fire
    btn = 4'b0110;
    wait_press(0);
    chk_i("sim_press3", int'(prs_h[3]), 1);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk_i("sim_rel3", int'(rel_h[3]), int'(k == 8));
      chk_i("sim_rel0", int'(rel_h[0]), int'(k == 10));
      chk_i("sim_hold", int'(hld_h), 0);
      chk_i("sim_deb0", int'(deb_h[0]), int'(k < 10));
      if (k == 2) btn[3] = 1'b1;
      if (k == 4) btn[0] = 1'b1;
    end

    // reset while ch2 is auto-repeating, button held through reset
    btn = 4'b1011;
    wait_press(2);
    repeat (17) step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_deb", deb_h | deb_d, 4'b0000);
    chk("midrst_pulses", prs_h | rel_h | hld_h, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      step();
      chk_i("postrst_press2", int'(prs_h[2]), int'(k == 6));
      chk_i("postrst_hold2", int'(hld_h[2]), int'(k == 16 || k == 21));
    end
    btn = 4'b1111;
    repeat (8) step();

    // random: fast toggling, then slow toggling to reach hold/repeat
    for (int i = 0; i < 5000; i++) begin
      if (i == 1500) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      step();
      for (int c = 0; c < N; c++) begin
        if (i < 2500) begin
          if ($urandom_range(0, 7) == 0) btn[c] = ~btn[c];
        end else begin
          if ($urandom_range(0, 39) == 0) btn[c] = ~btn[c];
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
